// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared CPU package for the fetch path.
// Holds the fetch FSM state type, reset PC, instruction width and PC step,
// plus a helper that forces a target address onto a halfword boundary.
// No ports (package).
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          INSTR_W  = 16;
  localparam logic [15:0] PC_STEP  = 16'd2;

  // Instructions are 16-bit aligned; bit 0 of any jump target is dropped.
  function automatic logic [15:0] align_pc(input logic [15:0] i_addr);
    return {i_addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pc_inc16.sv
// pc_inc16: 16-bit next-sequential-PC incrementer (+PC_STEP, wraps modulo 2^16).
// Shared between the fetch controller and the branch unit.
// Ports:
//   i_pc       in  16  current address
//   o_pc_next  out 16  i_pc + PC_STEP, 16'hFFFE wraps to 16'h0000
module pc_inc16
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [15:0] i_pc,
  output logic [15:0] o_pc_next
);

  // Sum truncated to 16 bits, which gives the wrap for free.
  assign o_pc_next = i_pc + PC_STEP;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction-fetch controller. Sole owner of the PC; issues one
// fetch at a time over a req/rdy handshake and holds the returned word until
// decode accepts it.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_stall                decode cannot accept the held word this cycle
//   i_redirect, i_redirect_pc  taken branch/jump and its target
//   i_halt                 decode saw HLT in the held word
//   o_imem_req, o_imem_addr    fetch request / address (held until i_imem_rdy)
//   i_imem_rdy, i_imem_data    one-cycle response pulse and returned word
//   o_instr_valid, o_instr, o_instr_pc  held word for decode
//   o_pc                   architectural PC
//   o_halted               fetch stopped until reset
//
// state  | meaning
// FETCH  | request outstanding at fetch_addr; data will be kept
// HOLD   | word in ibuf presented to decode, no request
// SQUASH | request outstanding for a redirected-away address; data dropped
// HALTED | HLT accepted; nothing happens until reset
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = pc_fetch_ctrl_pkg::RESET_PC,
  parameter int          INSTR_W  = pc_fetch_ctrl_pkg::INSTR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [15:0]        i_redirect_pc,
  input  logic               i_halt,
  output logic               o_imem_req,
  output logic [15:0]        o_imem_addr,
  input  logic               i_imem_rdy,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [15:0]        o_instr_pc,
  output logic [15:0]        o_pc,
  output logic               o_halted
);

  fetch_state_t       r_state, w_state_nxt;
  logic [15:0]        r_pc, w_pc_nxt;
  logic [15:0]        r_fetch_addr, w_fetch_addr_nxt;
  logic [INSTR_W-1:0] r_ibuf, w_ibuf_nxt;
  logic [15:0]        r_ibuf_pc, w_ibuf_pc_nxt;
  logic [15:0]        w_pc_plus2;
  logic [15:0]        w_redirect_tgt;

  pc_inc16 u_pc_inc (
    .i_pc      (r_pc),
    .o_pc_next (w_pc_plus2)
  );

  assign w_redirect_tgt = align_pc(i_redirect_pc);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_fetch_addr_nxt = r_fetch_addr;
    w_ibuf_nxt       = r_ibuf;
    w_ibuf_pc_nxt    = r_ibuf_pc;

    case (r_state)
      FETCH: begin
        if (i_imem_rdy && i_redirect) begin
          w_pc_nxt         = w_redirect_tgt;
          w_fetch_addr_nxt = w_redirect_tgt;
        end else if (i_imem_rdy) begin
          w_ibuf_nxt    = i_imem_data;
          w_ibuf_pc_nxt = r_fetch_addr;
          w_state_nxt   = HOLD;
        end else if (i_redirect) begin
          // fetch_addr must stay put: memory is still working on it.
          w_pc_nxt    = w_redirect_tgt;
          w_state_nxt = SQUASH;
        end
      end

      SQUASH: begin
        if (i_redirect) begin
          w_pc_nxt = w_redirect_tgt;
        end
        if (i_imem_rdy) begin
          // Restart at the newest redirect target, including one arriving now.
          w_fetch_addr_nxt = i_redirect ? w_redirect_tgt : r_pc;
          w_state_nxt      = FETCH;
        end
      end

      HOLD: begin
        if (i_redirect) begin
          w_pc_nxt         = w_redirect_tgt;
          w_fetch_addr_nxt = w_redirect_tgt;
          w_state_nxt      = FETCH;
        end else if (!i_stall && i_halt) begin
          w_pc_nxt    = w_pc_plus2;
          w_state_nxt = HALTED;
        end else if (!i_stall) begin
          w_pc_nxt         = w_pc_plus2;
          w_fetch_addr_nxt = w_pc_plus2;
          w_state_nxt      = FETCH;
        end
      end

      HALTED: begin
        w_state_nxt = HALTED;
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_ibuf       <= '0;
      r_ibuf_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_ibuf       <= w_ibuf_nxt;
      r_ibuf_pc    <= w_ibuf_pc_nxt;
    end
  end

  // Qualified with reset so nothing is requested or presented while rst is high.
  assign o_imem_req    = ((r_state == FETCH) || (r_state == SQUASH)) && !i_rst;
  assign o_instr_valid = (r_state == HOLD) && !i_rst;
  assign o_halted      = (r_state == HALTED) && !i_rst;
  assign o_imem_addr   = r_fetch_addr;
  assign o_instr       = r_ibuf;
  assign o_instr_pc    = r_ibuf_pc;
  assign o_pc          = r_pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl. A behavioural model of the fetch unit
// (outstanding-request / buffered-word / halted flags plus PC arithmetic)
// predicts every output each cycle; a random-latency memory answers requests.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, halt;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_rdy;
  logic [15:0] imem_addr, imem_data;
  logic        instr_valid, halted;
  logic [15:0] instr, instr_pc, pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_rdy    (imem_rdy),
    .i_imem_data   (imem_data),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_pc          (pc),
    .o_halted      (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic        m_known;
  logic [15:0] m_pc, m_fa, m_ibuf, m_ibuf_pc;
  logic        m_req, m_drop, m_valid, m_halted;
  int          mem_wait;
  int          halt_cnt;

  initial begin
    logic        n_rst;
    logic [15:0] tgt;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    redirect_pc = 16'h0; imem_rdy = 1'b0; imem_data = 16'h0;
    m_known = 1'b0; mem_wait = -1; halt_cnt = 0;
    m_pc = 0; m_fa = 0; m_ibuf = 0; m_ibuf_pc = 0;
    m_req = 0; m_drop = 0; m_valid = 0; m_halted = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (m_known) begin
        chk("imem_req", 32'(imem_req), 32'(m_req && !rst));
        if (m_req && !rst) chk("imem_addr", 32'(imem_addr), 32'(m_fa));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid && !rst));
        if (m_valid && !rst) begin
          chk("instr", 32'(instr), 32'(m_ibuf));
          chk("instr_pc", 32'(instr_pc), 32'(m_ibuf_pc));
        end
        chk("pc", 32'(pc), 32'(m_pc));
        chk("halted", 32'(halted), 32'(m_halted && !rst));
      end

      n_rst = (cyc < 2) || ($urandom % 150 == 0) || (m_halted && halt_cnt >= 22);
      stall    = ($urandom % 100) < 30;
      halt     = ($urandom % 100) < 5;
      redirect = ($urandom % 100) < 12;
      case ($urandom % 4)
        0:       redirect_pc = 16'hFFFE;
        1:       redirect_pc = 16'hFFFD;
        2:       redirect_pc = 16'h0040;
        default: redirect_pc = 16'($urandom);
      endcase
      imem_rdy = 1'b0;
      if (n_rst) begin
        mem_wait = -1;
      end else if (m_known && m_req) begin
        if (mem_wait < 0) mem_wait = int'($urandom_range(0, 3));
        if (mem_wait == 0) begin
          imem_rdy  = 1'b1;
          imem_data = 16'($urandom);
          mem_wait  = -1;
        end else begin
          mem_wait--;
        end
      end
      rst = n_rst;

      // Predict the effect of the coming rising edge.
      tgt = redirect_pc & 16'hFFFE;
      if (rst) begin
        m_known = 1'b1;
        m_pc = 16'h0000; m_fa = 16'h0000; m_ibuf = 0; m_ibuf_pc = 0;
        m_req = 1'b1; m_drop = 1'b0; m_valid = 1'b0; m_halted = 1'b0;
      end else if (m_halted) begin
        // nothing but reset matters
      end else if (m_valid) begin
        if (redirect) begin
          m_pc = tgt; m_fa = tgt; m_valid = 1'b0; m_req = 1'b1;
        end else if (!stall) begin
          m_pc = m_pc + 16'd2;
          m_valid = 1'b0;
          if (halt) m_halted = 1'b1;
          else begin m_fa = m_pc; m_req = 1'b1; end
        end
      end else if (m_req) begin
        if (m_drop) begin
          if (redirect) m_pc = tgt;
          if (imem_rdy) begin m_fa = m_pc; m_drop = 1'b0; end
        end else if (imem_rdy && redirect) begin
          m_pc = tgt; m_fa = tgt;
        end else if (imem_rdy) begin
          m_ibuf = imem_data; m_ibuf_pc = m_fa; m_valid = 1'b1; m_req = 1'b0;
        end else if (redirect) begin
          m_pc = tgt; m_drop = 1'b1;
        end
      end
      halt_cnt = m_halted ? halt_cnt + 1 : 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Instruction-fetch controller for the 16-bit pipeline. It owns the architectural PC, issues one fetch at a time to instruction memory or cache over a req/rdy handshake, and holds the returned word until decode accepts it. It sits between the instruction memory port and the decode stage, and is the sole writer of the PC.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- INSTR_W, 16, instruction word width.
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- stall  in  1  decode cannot accept this cycle.
- redirect  in  1  taken branch/jump from the execute stage.
- redirect_pc  in  16  redirect target; only meaningful while redirect=1.
- halt  in  1  decode has identified the held word as HLT.
- imem_req  out  1  fetch request; held until imem_rdy.
- imem_addr  out  16  fetch address; stable while imem_req=1.
- imem_rdy  in  1  one-cycle pulse; imem_data is valid in the same cycle.
- imem_data  in  INSTR_W  returned instruction word.
- instr_valid  out  1  instr and instr_pc are valid for decode.
- instr  out  INSTR_W  held instruction word.
- instr_pc  out  16  address of instr.
- pc  out  16  current architectural PC.
- halted  out  1  fetch permanently stopped until reset.

## Operation
- Registers:
  - pc
  - fetch_addr (drives imem_addr)
  - ibuf (drives instr)
  - ibuf_pc (drives instr_pc)
  - state
- States: FETCH, HOLD, SQUASH, HALTED.
- Reset:
  - state=FETCH, pc=fetch_addr=RESET_PC, ibuf=ibuf_pc=0.
  - imem_req, instr_valid and halted are all 0 during the reset cycle.
- FETCH: imem_req=1, imem_addr=fetch_addr.
  - imem_rdy and no redirect: ibuf<=imem_data, ibuf_pc<=fetch_addr, go to HOLD.
  - imem_rdy and redirect together: discard the data; pc<=fetch_addr<=redirect_pc; stay in FETCH.
  - redirect without imem_rdy: pc<=redirect_pc; go to SQUASH. fetch_addr is unchanged, so the address stays stable for the outstanding request.
- SQUASH: imem_req=1 at the old fetch_addr.
  - On imem_rdy: discard the data, fetch_addr<=pc, go to FETCH.
  - A further redirect only updates pc; the state remains SQUASH.
- HOLD: instr_valid=1, imem_req=0. Priority is redirect > halt > accept.
  - redirect: drop ibuf; pc<=fetch_addr<=redirect_pc; go to FETCH.
  - halt and no stall: pc<=pc+2; go to HALTED.
  - No stall: pc<=fetch_addr<=pc+2; go to FETCH.
  - stall: hold everything.
- HALTED: halted=1, imem_req=0, instr_valid=0. redirect, halt and stall are ignored; only rst exits.
- Arithmetic: pc+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000. Bit 0 of redirect_pc is forced to 0.
- Reset mid-operation abandons any outstanding request. Instruction memory is reset by the same rst, so no stale imem_rdy can arrive afterwards.

## Timing
- The earliest imem_req is in the first cycle after rst deasserts.
- Zero-wait memory (imem_rdy in the same cycle as imem_req): instr_valid rises on the next cycle.
- Peak throughput is one instruction per 2 cycles (FETCH then HOLD).
- An accept in HOLD at cycle N gives a new imem_req at cycle N+1 with address pc+2.
- A redirect takes effect on the pc output at the next edge.
- Squash costs the remaining memory latency plus 1 cycle.
- Outputs are registered or pure decodes of state; there is no combinational path from imem_rdy to instr_valid.

## Structure
- The shared CPU package holds:
  - the fetch_state_t enum (FETCH, HOLD, SQUASH, HALTED)
  - RESET_PC default
  - INSTR_W
  - the PC_STEP=2 constant
- One sub-module: pc_inc16, a 16-bit +2 incrementer with wrap, reused later by the branch unit.

## Test plan
- Reset with a 1-cycle-latency memory, stall=0 → imem_addr sequence 0000, 0002, 0004; instr_pc matches; pc reads 0006 after three accepts.
- HOLD with stall=1 for 5 cycles → instr and instr_pc stable, imem_req=0, pc unchanged. Release → next request at pc+2.
- 3-cycle memory, redirect to 0x0040 one cycle after the request → SQUASH; imem_addr stays at the old value until imem_rdy; data discarded; next request 0040; no instr_valid for the squashed word.
- redirect to 0x0100 in the same cycle as imem_rdy, and redirect to 0x0200 while in HOLD → data dropped; next fetch at 0100 and 0200 respectively.
- halt in HOLD at pc=0x0010 → halted=1, pc=0012, imem_req stays 0 for 20 cycles; a redirect during this time is ignored; rst returns pc to 0000.
- Wrap: redirect to FFFE, accept → next fetch 0000. Assert rst while in SQUASH → outputs return to reset values on the next edge.
